// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Power-up and recovery sequencer for the main clock PLL. It runs on the PLL
// reference clock. It holds the PLL in reset for a fixed time and then waits
// for a stable, synchronized lock. After that it releases the downstream
// domain resets one after another. A timeout retries the PLL reset a bounded
// number of times. Loss of lock after release re-runs the whole sequence.
//
// Ports:
//   refclk        in   reference clock, the only clock in the block
//   rst_n         in   synchronous active-low reset
//   pll_locked_i  in   PLL locked flag, asynchronous to refclk
//   relock_req_i  in   level request to restart the sequence from HOLD_RST
//   pll_rst_o     out  PLL reset, active-high
//   sys_rst_n_o   out  per-domain resets, active-low, released in index order
//   ready_o       out  all domains released and lock held
//   fail_o        out  retries exhausted
//   lock_lost_o   out  one-cycle pulse when lock drops after release
//   retry_count_o out  retries consumed in the current sequence
//   state_dbg_o   out  current FSM state encoding, for observation only
module pll_lock_sequencer #(
  parameter int RESET_CYCLES        = 500,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int N_DOMAINS           = 4,
  parameter int DOMAIN_STAGGER      = 16
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 pll_locked_i,
  input  logic                 relock_req_i,
  output logic                 pll_rst_o,
  output logic [N_DOMAINS-1:0] sys_rst_n_o,
  output logic                 ready_o,
  output logic                 fail_o,
  output logic                 lock_lost_o,
  output logic [7:0]           retry_count_o,
  output logic [2:0]           state_dbg_o
);

  typedef enum logic [2:0] {
    S_HOLD_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  // The phase counter is shared by HOLD_RST, STABLE and RELEASE. It has to
  // hold the largest terminal value of those three phases.
  localparam int REL_LAST = (N_DOMAINS - 1) * DOMAIN_STAGGER;
  localparam int M1       = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX  = (M1 > REL_LAST) ? M1 : REL_LAST;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int TW       = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [7:0]      retry_n;
  logic            lost_n;
  logic            sync1, locked_s;

  // Two-flop synchronizer. Every decision below uses locked_s only.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked_i;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= S_HOLD_RST;
      cnt           <= '0;
      tmo           <= '0;
      retry_count_o <= 8'd0;
      lock_lost_o   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tmo           <= tmo_n;
      retry_count_o <= retry_n;
      lock_lost_o   <= lost_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmo_n   = tmo;
    retry_n = retry_count_o;
    lost_n  = 1'b0;

    case (state)
      S_HOLD_RST: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(RESET_CYCLES - 1)) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK, S_STABLE: begin
        tmo_n = tmo + 1'b1;
        if (state == S_STABLE) cnt_n = cnt + 1'b1;
        // A timeout wins over stable-count completion and over a lock drop.
        if (tmo == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_count_o == 8'(MAX_RETRIES)) begin
            state_n = S_FAIL;
          end else begin
            retry_n = retry_count_o + 8'd1;
            state_n = S_HOLD_RST;
          end
        end else if (state == S_WAIT_LOCK) begin
          if (locked_s) state_n = S_STABLE;
        end else if (!locked_s) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = S_RELEASE;
        end
      end
      S_RELEASE, S_RUN: begin
        if (state == S_RELEASE) cnt_n = cnt + 1'b1;
        if (!locked_s) begin
          // A lock loss is not a timeout, so the retry budget starts afresh.
          state_n = S_HOLD_RST;
          retry_n = 8'd0;
          lost_n  = 1'b1;
        end else if (state == S_RELEASE && cnt == CW'(REL_LAST)) begin
          state_n = S_RUN;
        end
      end
      S_FAIL: begin
      end
      default: state_n = S_HOLD_RST;
    endcase

    if (relock_req_i) begin
      state_n = S_HOLD_RST;
      retry_n = 8'd0;
      lost_n  = 1'b0;
    end

    // The phase counter restarts on every state entry. A held relock request
    // also restarts it, because it re-enters HOLD_RST every cycle.
    if (state_n != state || relock_req_i) cnt_n = '0;
    if (state == S_HOLD_RST && state_n != S_HOLD_RST) tmo_n = '0;
  end

  always_comb begin
    pll_rst_o   = (state == S_HOLD_RST) || (state == S_FAIL);
    ready_o     = (state == S_RUN);
    fail_o      = (state == S_FAIL);
    state_dbg_o = state;
    sys_rst_n_o = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      sys_rst_n_o[i] = (state == S_RUN) ||
                       ((state == S_RELEASE) && (cnt >= CW'(i * DOMAIN_STAGGER)));
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer with small parameters. The reference model
// works on whole phases of the sequence. It computes from the lock and relock
// traces when each phase ends and fills one expected word per cycle into
// exp_q. Every cycle, the bench checks the DUT outputs against the word at the
// head of exp_q.
module tb_pll_lock_sequencer;

  localparam int NMAX   = 1100;
  localparam int MAXRTY = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       relock_req_i;
  logic       pll_rst_o;
  logic [2:0] sys_rst_n_o;
  logic       ready_o;
  logic       fail_o;
  logic       lock_lost_o;
  logic [7:0] retry_count_o;
  logic [2:0] state_dbg_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit lk[NMAX];
  bit rl[NMAX];
  // {pll_rst, sys_rst_n[2:0], ready, fail, lock_lost, retry[7:0]}
  logic [14:0] exp_q[$];

  int first_ready, first_fail, rst_hi, lost_cnt;

  pll_lock_sequencer #(
    .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(MAXRTY), .N_DOMAINS(3), .DOMAIN_STAGGER(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked_i(pll_locked_i),
    .relock_req_i(relock_req_i), .pll_rst_o(pll_rst_o), .sys_rst_n_o(sys_rst_n_o),
    .ready_o(ready_o), .fail_o(fail_o), .lock_lost_o(lock_lost_o),
    .retry_count_o(retry_count_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock ----------------
  always #5 refclk = ~refclk;

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronized lock seen in cycle k is the raw input of cycle k-2.
  function automatic bit ls_at(input int k);
    if (k < 2) return 1'b0;
    return lk[k-2];
  endfunction

  // The lock must be seen in the WAIT_LOCK cycle and in all eight STABLE
  // cycles that follow it.
  function automatic bit run9(input int e);
    for (int j = 0; j < 9; j++) if (!ls_at(e + j)) return 1'b0;
    return 1'b1;
  endfunction

  // Phases: 0 hold, 1 waiting for lock (WAIT_LOCK/STABLE), 2 release+run, 3 fail.
  task automatic build_model(input int len);
    int t, n, ph, nph, retry, nretry, m;
    bit lost, pend_lost, found, pll, rdy, fl;
    logic [2:0] s;
    t = 0; ph = 0; retry = 0; pend_lost = 1'b0;
    while (t < len) begin
      lost = 1'b0; nph = 0; nretry = 0; n = NMAX * 4;
      case (ph)
        0: begin n = t + 4; nph = 1; nretry = retry; end
        1: begin
          n = t + 32;
          if (retry == MAXRTY) begin nph = 3; nretry = retry; end
          else begin nph = 0; nretry = retry + 1; end
          found = 1'b0;
          // The release decision must land before the timeout cycle t+31.
          for (int e = t; e <= t + 22 && !found; e++) begin
            if (run9(e)) begin found = 1'b1; n = e + 9; nph = 2; nretry = retry; end
          end
        end
        2: begin
          for (int c = t; c < len && !lost; c++) begin
            if (!ls_at(c)) begin lost = 1'b1; n = c + 1; nph = 0; nretry = 0; end
          end
        end
        default: ;
      endcase
      found = 1'b0;
      for (int r = t; r < n && r < len && !found; r++) begin
        if (rl[r]) begin found = 1'b1; n = r + 1; nph = 0; nretry = 0; lost = 1'b0; end
      end
      for (int k = t; k < n && k < len; k++) begin
        m = k - t; s = 3'b000; pll = 1'b0; rdy = 1'b0; fl = 1'b0;
        case (ph)
          0: pll = 1'b1;
          2: begin
            for (int i = 0; i < 3; i++) s[i] = (m >= 2 * i);
            rdy = (m >= 5);
          end
          3: begin pll = 1'b1; fl = 1'b1; end
          default: ;
        endcase
        exp_q.push_back({pll, s, rdy, fl, (k == t) && pend_lost, 8'(retry)});
      end
      pend_lost = lost; t = n; ph = nph; retry = nretry;
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic check_cycle(input int k);
    logic [14:0] w;
    w = exp_q.pop_front();
    chk("pll_rst",     k, {7'd0, pll_rst_o},     {7'd0, w[14]});
    chk("sys_rst_n",   k, {5'd0, sys_rst_n_o},   {5'd0, w[13:11]});
    chk("ready",       k, {7'd0, ready_o},       {7'd0, w[10]});
    chk("fail",        k, {7'd0, fail_o},        {7'd0, w[9]});
    chk("lock_lost",   k, {7'd0, lock_lost_o},   {7'd0, w[8]});
    chk("retry_count", k, retry_count_o,         w[7:0]);
    if (ready_o === 1'b1 && first_ready < 0) first_ready = k;
    if (fail_o === 1'b1 && first_fail < 0) first_fail = k;
    if (pll_rst_o === 1'b1) rst_hi++;
    if (lock_lost_o === 1'b1) lost_cnt++;
  endtask

  // Cycle 0 is the state after the last reset edge. The inputs for cycle k
  // are driven after cycle k has been checked.
  task automatic run_seq(input int len);
    exp_q.delete();
    build_model(len);
    first_ready = -1; first_fail = -1; rst_hi = 0; lost_cnt = 0;
    rst_n = 1'b0; pll_locked_i = 1'b0; relock_req_i = 1'b0;
    repeat (3) @(posedge refclk);
    for (int k = 0; k < len; k++) begin
      @(negedge refclk);
      check_cycle(k);
      rst_n = 1'b1;
      pll_locked_i = lk[k];
      relock_req_i = rl[k];
    end
  endtask

  task automatic clear_traces();
    for (int k = 0; k < NMAX; k++) begin lk[k] = 1'b0; rl[k] = 1'b0; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; pll_locked_i = 1'b0; relock_req_i = 1'b0;

    // 1: lock always present.
    clear_traces();
    for (int k = 0; k < NMAX; k++) lk[k] = 1'b1;
    run_seq(40);
    chk("s1_first_ready", 0, 8'(first_ready), 8'd18);
    chk("s1_pll_rst_cycles", 0, 8'(rst_hi), 8'd4);

    // 2: lock never present.
    clear_traces();
    run_seq(120);
    chk("s2_first_fail", 0, 8'(first_fail), 8'd108);

    // 3: lock present only during the second attempt.
    clear_traces();
    for (int k = 36; k < NMAX; k++) lk[k] = 1'b1;
    run_seq(70);
    chk("s3_first_ready", 0, 8'(first_ready), 8'd54);

    // 4: one-cycle lock drop while running.
    clear_traces();
    for (int k = 0; k < NMAX; k++) lk[k] = (k != 30);
    run_seq(80);
    chk("s4_lost_pulses", 0, 8'(lost_cnt), 8'd1);

    // 5: lock toggling every 4 cycles never becomes stable.
    clear_traces();
    for (int k = 0; k < NMAX; k++) lk[k] = ((k / 4) % 2) == 1;
    run_seq(120);
    chk("s5_first_fail", 0, 8'(first_fail), 8'd108);

    // 6: relock from FAIL, with lock arriving meanwhile.
    clear_traces();
    for (int k = 100; k < NMAX; k++) lk[k] = 1'b1;
    rl[110] = 1'b1;
    run_seq(160);
    chk("s6_first_fail", 0, 8'(first_fail), 8'd108);
    chk("s6_first_ready", 0, 8'(first_ready), 8'd129);

    // 6b: reset asserted while in RELEASE.
    clear_traces();
    for (int k = 0; k < NMAX; k++) lk[k] = 1'b1;
    run_seq(15);
    rst_n = 1'b0;
    @(posedge refclk);
    @(negedge refclk);
    chk("rst_mid_pll_rst", 0, {7'd0, pll_rst_o}, 8'd1);
    chk("rst_mid_sys_rst_n", 0, {5'd0, sys_rst_n_o}, 8'd0);
    chk("rst_mid_ready", 0, {7'd0, ready_o}, 8'd0);
    chk("rst_mid_fail", 0, {7'd0, fail_o}, 8'd0);
    chk("rst_mid_lock_lost", 0, {7'd0, lock_lost_o}, 8'd0);
    chk("rst_mid_retry", 0, retry_count_o, 8'd0);

    // Random lock waveforms with occasional relock pulses.
    for (int trial = 0; trial < 4; trial++) begin
      int k;
      bit v;
      clear_traces();
      k = 0; v = 1'b0;
      while (k < NMAX) begin
        int len;
        len = v ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 12));
        for (int j = 0; j < len && k < NMAX; j++) begin lk[k] = v; k++; end
        v = ~v;
      end
      for (int j = 0; j < NMAX; j++) rl[j] = ($urandom_range(0, 199) == 0);
      run_seq(700);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Power-up and recovery sequencer for the main clock PLL, running on the PLL reference clock.
- Holds the PLL in reset for a fixed time, then waits for a debounced, stable lock.
- Releases downstream domain resets one after another, in a staggered order.
- On timeout, retries the PLL reset a bounded number of times. On loss of lock, re-runs the full sequence.
- Sits between the board reset and the PLL wrapper. Its reset outputs drive the core clock domains.

Parameters:
RESET_CYCLES, 500, refclk cycles pll_rst_o is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 5000, consecutive cycles of synchronized lock required (>=1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed from PLL reset release to stable lock (>LOCK_STABLE_CYCLES)
MAX_RETRIES, 3, extra attempts after the first before giving up (0..255)
N_DOMAINS, 4, number of downstream reset outputs (1..16)
DOMAIN_STAGGER, 16, cycles between successive domain reset releases (>=1)

Ports:
refclk  in  1  reference clock; the only clock in the block
rst_n  in  1  synchronous, active-low reset
pll_locked_i  in  1  PLL locked flag; asynchronous to refclk
relock_req_i  in  1  level request to restart the sequence from HOLD_RST
pll_rst_o  out  1  PLL reset, active-high
sys_rst_n_o  out  N_DOMAINS  per-domain reset, active-low
ready_o  out  1  all domains released, lock held
fail_o  out  1  retries exhausted
lock_lost_o  out  1  one-cycle pulse on lock loss after release
retry_count_o  out  8  retries consumed in the current sequence

Behaviour:
- Interface: one clock, refclk. Reset rst_n is synchronous and active-low.
- rst_n low at an edge:
  - state=HOLD_RST; all counters 0; retry_count_o=0.
  - pll_rst_o=1, sys_rst_n_o=0, ready_o=0, fail_o=0, lock_lost_o=0.
- Lock synchronizer: pll_locked_i passes through a 2-flop synchronizer to give locked_s. Both flops reset to 0. All decisions use locked_s.
- Outputs are Moore-decoded from the state register plus the release counter. lock_lost_o is registered.
- Counters:
  - cnt: phase counter, cleared on every state entry.
  - tmo: timeout counter, cleared on HOLD_RST exit, runs through WAIT_LOCK and STABLE.
- States:
  - HOLD_RST: pll_rst_o=1. After RESET_CYCLES cycles in the state, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0. locked_s=1 -> STABLE.
  - STABLE: locked_s=0 -> WAIT_LOCK (tmo keeps running). cnt reaches LOCK_STABLE_CYCLES -> RELEASE.
  - Timeout (WAIT_LOCK or STABLE): when tmo reaches LOCK_TIMEOUT_CYCLES:
    - retry_count_o==MAX_RETRIES -> FAIL.
    - otherwise retry_count_o+1 and go to HOLD_RST.
  - RELEASE: sys_rst_n_o[i]=1 once cnt >= i*DOMAIN_STAGGER. Domain 0 is released on the first RELEASE cycle. When cnt==(N_DOMAINS-1)*DOMAIN_STAGGER -> RUN.
  - RUN: ready_o=1 and all sys_rst_n_o=1.
  - FAIL: pll_rst_o=1, sys_rst_n_o=0, fail_o=1. Stays in FAIL until relock_req_i or rst_n.
- Lock loss in RELEASE or RUN (locked_s=0):
  - Next edge: state=HOLD_RST, all sys_rst_n_o=0, ready_o=0, lock_lost_o=1 for exactly one cycle.
  - retry_count_o cleared to 0; lock loss is not a timeout.
  - Latency: 3 edges from pll_locked_i falling to outputs changing.
- relock_req_i=1 in any state:
  - Next state HOLD_RST with cnt=0 and retry_count_o=0; fail_o clears.
  - Held high, it keeps the block in HOLD_RST, and cnt restarts each cycle.
- Priority, highest first: rst_n, relock_req_i, lock loss, timeout, normal transition.
- Simultaneous timeout and stable-count completion in STABLE: timeout wins.
- Reset mid-sequence: rst_n low at any point behaves as the power-up reset, regardless of state.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, N_DOMAINS=3, DOMAIN_STAGGER=2.
1. pll_locked_i held 1, rst_n released -> timing after release:
   - pll_rst_o high exactly 4 cycles.
   - sys_rst_n_o = 001, 011, 111 at cycles 13, 15, 17.
   - ready_o=1 at cycle 18.
2. pll_locked_i held 0 -> fail_o=1 after 3*(4+32)=108 cycles. retry_count_o=2, pll_rst_o=1, sys_rst_n_o=000.
3. Lock present only on the 2nd attempt -> retry_count_o=1, then normal release. ready_o rises 36 cycles later than in scenario 1.
4. In RUN, drop pll_locked_i for 1 cycle -> 3 edges later:
   - lock_lost_o pulses once; sys_rst_n_o=000; ready_o=0; pll_rst_o=1.
   - the full sequence reruns.
5. Toggle pll_locked_i every 4 cycles after PLL reset release -> STABLE never completes; the timeout retries and FAIL follow as in scenario 2.
6. In FAIL, pulse relock_req_i one cycle -> fail_o=0 and retry_count_o=0 next edge, HOLD_RST restarts. Also assert rst_n low in RELEASE -> all outputs return to reset values next edge.
